// File: rtl/spi_port_pkg.sv
// Shared constants for the SPI host: register offsets, STATUS bit positions
// and shift-engine state encodings.
package spi_port_pkg;

  localparam logic [1:0] SPI_OFS_DATA   = 2'd0;
  localparam logic [1:0] SPI_OFS_CTRL   = 2'd1;
  localparam logic [1:0] SPI_OFS_STATUS = 2'd2;
  localparam logic [1:0] SPI_OFS_DIV    = 2'd3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVF      = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } spi_state_t;

  function automatic logic [7:0] spi_status(input logic busy, input logic rx_avail,
                                            input logic rx_full, input logic tx_full,
                                            input logic ovf);
    logic [7:0] s;
    s = '0;
    s[STAT_BUSY]     = busy;
    s[STAT_RX_AVAIL] = rx_avail;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// First-word-fall-through FIFO; a push to a full FIFO is accepted when a pop
// happens in the same cycle.
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_full, w_empty, w_push_ok, w_pop_ok;

  // Extra pointer MSB tells full from empty when the indices match.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/spi_port.sv
// IO-mapped SPI host (mode 0, MSB first) with TX/RX FIFOs, chip-select and divider
// registers. Define SPI_PORT_IRQ_EN to add the oIrq output and the CTRL[7] enable.
module spi_port
  import spi_port_pkg::*;
#(
  parameter logic [11:0] BASE        = 12'h0B8,
  parameter int          NUM_CS      = 2,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [7:0]  DEFAULT_DIV = 8'd7
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [19:0]       iAddr,
  input  logic [7:0]        iData,
  input  logic              iWr,
  input  logic              iRd,
  output logic              oSel,
  output logic [7:0]        oData,
  output logic              oSck,
  output logic              oMosi,
  input  logic              iMiso,
  output logic [NUM_CS-1:0] oCs,
`ifdef SPI_PORT_IRQ_EN
  output logic              oIrq,
`endif
  output logic              oBusy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic w_hit, w_wr, w_rd, w_busy, w_ien, w_ovf_set;
  logic [1:0] w_ofs;
  logic [7:0] w_rd_data, w_ctrl_rd;

  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]    w_tx_dout, w_rx_dout;
  logic [CW-1:0] w_tx_count, w_rx_count;

  spi_state_t        r_state, w_state_next;
  logic [7:0]        r_cnt, w_cnt_next, r_shift, w_shift_next, r_rx, w_rx_next;
  logic [7:0]        r_div_lat, w_div_lat_next, r_div;
  logic [2:0]        r_bit, w_bit_next;
  logic              r_sck, w_sck_next, r_mosi, w_mosi_next, r_ovf;
  logic [NUM_CS-1:0] r_cs;

  assign w_hit = (iAddr[11:2] == BASE[11:2]);
  assign w_wr  = iWr && w_hit;
  assign w_rd  = iRd && w_hit;
  assign w_ofs = iAddr[1:0];

  assign w_tx_push = w_wr && (w_ofs == SPI_OFS_DATA);
  assign w_tx_pop  = (r_state == S_LOAD);
  assign w_rx_push = (r_state == S_DONE);
  assign w_rx_pop  = w_rd && (w_ofs == SPI_OFS_DATA);
  assign w_ovf_set = (w_tx_push && w_tx_full && !w_tx_pop) ||
                     (w_rx_push && w_rx_full && !w_rx_pop);
  assign w_busy    = (r_state != S_IDLE) || !w_tx_empty;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(iClk), .i_rst(iRst), .i_push(w_tx_push), .i_din(iData), .i_pop(w_tx_pop),
    .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(iClk), .i_rst(iRst), .i_push(w_rx_push), .i_din(r_rx), .i_pop(w_rx_pop),
    .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_next     = r_bit;
    w_shift_next   = r_shift;
    w_rx_next      = r_rx;
    w_div_lat_next = r_div_lat;
    w_sck_next     = r_sck;
    w_mosi_next    = r_mosi;
    unique case (r_state)
      S_IDLE: if (!w_tx_empty) w_state_next = S_LOAD;
      S_LOAD: begin
        w_shift_next   = w_tx_dout;
        w_div_lat_next = r_div;
        w_mosi_next    = w_tx_dout[7];
        w_cnt_next     = '0;
        w_bit_next     = 3'd7;
        w_sck_next     = 1'b0;
        w_state_next   = S_LO;
      end
      S_LO: begin
        if (r_cnt == r_div_lat) begin
          w_state_next = S_HI;
          w_cnt_next   = '0;
          w_sck_next   = 1'b1;
          w_rx_next    = {r_rx[6:0], iMiso};
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_HI: begin
        if (r_cnt == r_div_lat) begin
          w_cnt_next = '0;
          w_sck_next = 1'b0;
          if (r_bit == 3'd0) begin
            w_state_next = S_DONE;
            w_mosi_next  = 1'b1;
          end else begin
            w_state_next = S_LO;
            w_bit_next   = r_bit - 3'd1;
            w_shift_next = {r_shift[6:0], 1'b0};
            w_mosi_next  = r_shift[6];
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_mosi_next  = 1'b1;
        w_state_next = w_tx_empty ? S_IDLE : S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_div_lat <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit     <= w_bit_next;
      r_shift   <= w_shift_next;
      r_rx      <= w_rx_next;
      r_div_lat <= w_div_lat_next;
      r_sck     <= w_sck_next;
      r_mosi    <= w_mosi_next;
    end
  end

  always_comb begin
    w_ctrl_rd               = '0;
    w_ctrl_rd[NUM_CS-1:0]   = r_cs;
    w_ctrl_rd[7]            = w_ien;
    case (w_ofs)
      SPI_OFS_DATA:   w_rd_data = w_rx_empty ? 8'hFF : w_rx_dout;
      SPI_OFS_CTRL:   w_rd_data = w_ctrl_rd;
      SPI_OFS_STATUS: w_rd_data = spi_status(w_busy, !w_rx_empty, w_rx_full, w_tx_full, r_ovf);
      default:        w_rd_data = r_div;
    endcase
  end

  // An overflow in the same cycle as a STATUS read stays set so it is not lost.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cs  <= '1;
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
      oSel  <= 1'b0;
      oData <= 8'h00;
    end else begin
      if (w_wr && (w_ofs == SPI_OFS_CTRL)) r_cs  <= iData[NUM_CS-1:0];
      if (w_wr && (w_ofs == SPI_OFS_DIV))  r_div <= iData;
      if (w_ovf_set)                                  r_ovf <= 1'b1;
      else if (w_rd && (w_ofs == SPI_OFS_STATUS))     r_ovf <= 1'b0;
      oSel  <= w_rd;
      oData <= w_rd ? w_rd_data : 8'hFF;
    end
  end

`ifdef SPI_PORT_IRQ_EN
  logic r_ien, r_irq, w_ien_next, w_rx_avail_next, w_rx_push_ok, w_rx_pop_ok;

  assign w_rx_pop_ok     = w_rx_pop && !w_rx_empty;
  assign w_rx_push_ok    = w_rx_push && (!w_rx_full || w_rx_pop_ok);
  assign w_rx_avail_next = w_rx_push_ok || (w_rx_pop_ok ? (w_rx_count > CW'(1)) : !w_rx_empty);
  assign w_ien_next      = (w_wr && (w_ofs == SPI_OFS_CTRL)) ? iData[7] : r_ien;

  // Computed from next-state values so oIrq tracks the condition without extra lag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ien <= w_ien_next;
      r_irq <= w_ien_next && w_rx_avail_next && (w_state_next == S_IDLE);
    end
  end

  assign w_ien = r_ien;
  assign oIrq  = r_irq;
`else
  assign w_ien = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{iAddr[19:12], iData, w_tx_count, w_rx_count};

  assign oSck  = r_sck;
  assign oMosi = r_mosi;
  assign oCs   = r_cs;
  assign oBusy = w_busy;

endmodule
